// File: rtl/qtree_pkg.sv
// Shared types for the quadtree lookup pipeline: leaf table entries, leaf
// results and the drop-counter width.
package qtree_pkg;

  localparam int LEAF_KEY_W   = 16;
  localparam int LEAF_VALUE_W = 16;
  localparam int DROP_CNT_W   = 16;

  typedef struct packed {
    logic                    vld;
    logic [LEAF_KEY_W-1:0]   key;
    logic [LEAF_VALUE_W-1:0] value;
  } leaf_entry_t;

  typedef struct packed {
    logic                    hit;
    logic [LEAF_VALUE_W-1:0] value;
    logic [LEAF_KEY_W-1:0]   key;
  } leaf_result_t;

endpackage

// File: rtl/qleaf_fifo.sv
// Show-ahead result FIFO: the head lives in its own register so the outputs
// never come straight from the storage array. Flags a push that cannot land.
module qleaf_fifo
  import qtree_pkg::*;
#(
  parameter  int DEPTH       = 8,
  parameter  int AFULL_LEVEL = 6,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int LVL_W       = PTR_W + 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  leaf_result_t push_data_i,
  input  logic         pop_i,
  output leaf_result_t head_o,
  output logic         valid_o,
  output logic [LVL_W-1:0] level_o,
  output logic         almost_full_o,
  output logic         drop_o
);

  leaf_result_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;

  assign full    = (level_o == LVL_W'(DEPTH));
  assign empty   = (level_o == '0);
  assign pop     = pop_i && valid_o;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && !push_ok;

  always_comb begin
    level_nxt = level_o;
    if (push_ok && !pop)      level_nxt = level_o + 1'b1;
    else if (pop && !push_ok) level_nxt = level_o - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_o       <= '0;
      valid_o       <= 1'b0;
      almost_full_o <= 1'b0;
      head_o        <= '0;
    end else begin
      level_o       <= level_nxt;
      valid_o       <= (level_nxt != '0);
      almost_full_o <= (level_nxt >= LVL_W'(AFULL_LEVEL));
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      // Head reloads from the incoming entry when it becomes the oldest one.
      if (push_ok && (empty || (pop && level_o == LVL_W'(1))))
        head_o <= push_data_i;
      else if (pop && level_o > LVL_W'(1))
        head_o <= mem[rd_ptr + 1'b1];
    end
  end

endmodule

// File: rtl/simple_ram.sv
// Single-port-write, single-port-read RAM with a registered read; a read and
// write to the same address in one cycle returns the old contents.
module simple_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 33
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

  // NOTE: storage arrays carry no reset; clearing them would need a
  // per-entry reset mux and the table contents must survive reset anyway.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/qleaf_stage.sv
// Terminal leaf stage: leaf table read, exact-key compare, and a result FIFO
// that counts and flags drops because the tree pipeline cannot stall.
module qleaf_stage
  import qtree_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_LEVEL  = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          ctrl_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]         ctrl_wr_addr_i,
  input  logic [$bits(leaf_entry_t)-1:0] ctrl_wr_data_i,
  input  logic                          lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0]         lookup_addr_i,
  input  logic [DATA_WIDTH-1:0]         lookup_data_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic                          res_hit_o,
  output logic [RESULT_WIDTH-1:0]       res_value_o,
  output logic [DATA_WIDTH-1:0]         res_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          almost_full_o,
  output logic                          overflow_o,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o
);

  leaf_entry_t     ram_q;
  logic            d1_valid;
  logic [DATA_WIDTH-1:0] d1_key;
  logic            d2_valid;
  leaf_result_t    d2_result;
  leaf_result_t    result_c;
  leaf_result_t    head;
  logic            drop;

  simple_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH ($bits(leaf_entry_t))
  ) u_leaf_ram (
    .clk_i   (clk_i),
    .wr_en   (ctrl_wr_en_i),
    .wr_addr (ctrl_wr_addr_i),
    .wr_data (ctrl_wr_data_i),
    .rd_addr (lookup_addr_i),
    .rd_data (ram_q)
  );

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    result_c       = '0;
    result_c.hit   = ram_q.vld && (ram_q.key == d1_key);
    result_c.value = result_c.hit ? ram_q.value : '0;
    result_c.key   = d1_key;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      d1_valid   <= 1'b0;
      d1_key     <= '0;
      d2_valid   <= 1'b0;
      d2_result  <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      d1_valid  <= lookup_valid_i;
      d1_key    <= lookup_data_i;
      d2_valid  <= d1_valid;
      d2_result <= result_c;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  qleaf_fifo #(
    .DEPTH       (FIFO_DEPTH),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .push_i        (d2_valid),
    .push_data_i   (d2_result),
    .pop_i         (res_ready_i),
    .head_o        (head),
    .valid_o       (res_valid_o),
    .level_o       (level_o),
    .almost_full_o (almost_full_o),
    .drop_o        (drop)
  );

  assign res_hit_o   = head.hit;
  assign res_value_o = head.value;
  assign res_data_o  = head.key;

endmodule

// File: tb/tb_qleaf_stage.sv
// Directed bench for qleaf_stage: hit/miss, overflow, full with pop,
// read/write collision and reset mid-stream.
module tb_qleaf_stage;
  import qtree_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ctrl_wr_en_i;
  logic [5:0]  ctrl_wr_addr_i;
  logic [32:0] ctrl_wr_data_i;
  logic        lookup_valid_i;
  logic [5:0]  lookup_addr_i;
  logic [15:0] lookup_data_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_hit_o;
  logic [15:0] res_value_o;
  logic [15:0] res_data_o;
  logic [3:0]  level_o;
  logic        almost_full_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  qleaf_stage dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .ctrl_wr_en_i   (ctrl_wr_en_i),
    .ctrl_wr_addr_i (ctrl_wr_addr_i),
    .ctrl_wr_data_i (ctrl_wr_data_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_addr_i  (lookup_addr_i),
    .lookup_data_i  (lookup_data_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_hit_o      (res_hit_o),
    .res_value_o    (res_value_o),
    .res_data_o     (res_data_o),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_leaf(input logic [5:0] addr, input logic [32:0] entry);
    ctrl_wr_en_i   = 1'b1;
    ctrl_wr_addr_i = addr;
    ctrl_wr_data_i = entry;
    tick();
    ctrl_wr_en_i   = 1'b0;
  endtask

  task automatic set_lookup(input logic v, input logic [5:0] addr, input logic [15:0] key);
    lookup_valid_i = v;
    lookup_addr_i  = addr;
    lookup_data_i  = key;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_key;
    rst_n_i        = 1'b0;
    ctrl_wr_en_i   = 1'b0;
    ctrl_wr_addr_i = '0;
    ctrl_wr_data_i = '0;
    res_ready_i    = 1'b0;
    set_lookup(1'b0, 6'd0, 16'h0);
    tick();
    tick();
    check("rst_valid", res_valid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_afull", almost_full_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_payload", {res_hit_o, res_value_o, res_data_o}, 0);
    rst_n_i = 1'b1;
    tick();

    write_leaf(6'd5, {1'b1, 16'h1234, 16'hBEEF});
    write_leaf(6'd7, {1'b0, 16'h5555, 16'h1111});
    write_leaf(6'd3, {1'b1, 16'hAAAA, 16'h0001});

    // Hit: lookup at edge N, result visible after edge N+2.
    res_ready_i = 1'b1;
    set_lookup(1'b1, 6'd5, 16'h1234);
    tick();
    set_lookup(1'b0, 6'd0, 16'h0);
    tick();
    check("hit_lat_n1", res_valid_o, 0);
    tick();
    check("hit_valid", res_valid_o, 1);
    check("hit_hit", res_hit_o, 1);
    check("hit_value", res_value_o, 16'hBEEF);
    check("hit_data", res_data_o, 16'h1234);
    tick();
    check("hit_popped", res_valid_o, 0);

    // Miss on key mismatch.
    set_lookup(1'b1, 6'd5, 16'h1235);
    tick();
    set_lookup(1'b0, 6'd0, 16'h0);
    tick();
    tick();
    check("miss_valid", res_valid_o, 1);
    check("miss_hit", res_hit_o, 0);
    check("miss_value", res_value_o, 0);
    check("miss_data", res_data_o, 16'h1235);
    tick();

    // Miss on invalid entry with matching key.
    set_lookup(1'b1, 6'd7, 16'h5555);
    tick();
    set_lookup(1'b0, 6'd0, 16'h0);
    tick();
    tick();
    check("nvld_valid", res_valid_o, 1);
    check("nvld_hit", res_hit_o, 0);
    check("nvld_value", res_value_o, 0);
    tick();

    // Overflow: ready low, 10 back-to-back lookups into depth 8.
    res_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_lookup(1'b1, 6'd5, 16'h0100 + 16'(i));
      tick();
      if (i == 6) check("ovf_afull_after5", almost_full_o, 0);
      if (i == 7) begin
        check("ovf_afull_after6", almost_full_o, 1);
        check("ovf_level6", level_o, 6);
      end
    end
    set_lookup(1'b0, 6'd0, 16'h0);
    tick();
    tick();
    check("ovf_level", level_o, 8);
    check("ovf_drop_cnt", drop_cnt_o, 2);
    check("ovf_flag", overflow_o, 1);
    check("ovf_afull", almost_full_o, 1);
    res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", res_valid_o, 1);
      check("drain_data", res_data_o, 16'h0100 + 16'(i));
      tick();
    end
    check("drain_empty", res_valid_o, 0);
    check("drain_level", level_o, 0);
    check("drain_afull", almost_full_o, 0);
    check("drain_ovf_sticky", overflow_o, 1);

    // Full with simultaneous pop: continuous lookups, ready raised at level 8.
    res_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_lookup(1'b1, 6'd5, 16'h0200 + 16'(i));
      res_ready_i = (i >= 10);
      if (i >= 10) begin
        check("fullpop_level", level_o, 8);
        check("fullpop_data", res_data_o, 16'h0200 + 16'(i - 10));
      end
      tick();
    end
    set_lookup(1'b0, 6'd0, 16'h0);
    exp_key = 16'h020A;
    for (int i = 0; i < 20; i++) begin
      if (res_valid_o) begin
        check("fullpop_drain", res_data_o, exp_key);
        exp_key++;
      end
      tick();
    end
    check("fullpop_count", exp_key, 16'h0214);
    check("fullpop_nodrop", drop_cnt_o, 2);
    check("fullpop_empty", level_o, 0);

    // Collision: write and read addr 3 in the same cycle, then read again.
    res_ready_i = 1'b0;
    ctrl_wr_en_i   = 1'b1;
    ctrl_wr_addr_i = 6'd3;
    ctrl_wr_data_i = {1'b1, 16'hAAAA, 16'h0002};
    set_lookup(1'b1, 6'd3, 16'hAAAA);
    tick();
    ctrl_wr_en_i = 1'b0;
    tick();
    set_lookup(1'b0, 6'd0, 16'h0);
    tick();
    check("coll_old_value", res_value_o, 16'h0001);
    check("coll_old_hit", res_hit_o, 1);
    tick();
    check("coll_level", level_o, 2);
    res_ready_i = 1'b1;
    tick();
    check("coll_new_value", res_value_o, 16'h0002);
    tick();
    check("coll_empty", res_valid_o, 0);

    // Reset mid-stream: 4 buffered, 2 in flight, lookup during reset.
    res_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_lookup(1'b1, 6'd5, 16'h0400 + 16'(i));
      tick();
    end
    check("mrst_pre_level", level_o, 4);
    rst_n_i = 1'b0;
    set_lookup(1'b1, 6'd5, 16'h04FF);
    tick();
    check("mrst_valid", res_valid_o, 0);
    check("mrst_level", level_o, 0);
    check("mrst_afull", almost_full_o, 0);
    check("mrst_ovf", overflow_o, 0);
    check("mrst_drop", drop_cnt_o, 0);
    check("mrst_payload", {res_hit_o, res_value_o, res_data_o}, 0);
    rst_n_i = 1'b1;
    res_ready_i = 1'b1;
    set_lookup(1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst_quiet", {res_valid_o, level_o}, 0);
    end
    set_lookup(1'b1, 6'd5, 16'h1234);
    tick();
    set_lookup(1'b0, 6'd0, 16'h0);
    tick();
    tick();
    check("mrst_ram_valid", res_valid_o, 1);
    check("mrst_ram_hit", res_hit_o, 1);
    check("mrst_ram_value", res_value_o, 16'hBEEF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
